divider_8by4_seq: RTL and testbench
===================================

Name: divider_8by4_seq

Overview:
- Sequential unsigned restoring divider. It is the inverse of the team's 4-bit multiplier: it takes an 8-bit dividend (a product-width value) and a 4-bit divisor, and returns the quotient and remainder.
- Computes one quotient bit per clock.
- Valid/ready handshakes on both input and output, so it sits in the synthesis-test datapath beside the multiplier.
- Round-trip property: quotient*divisor + remainder == dividend.

Parameters:
- DW, 8, dividend and quotient width (iteration count).
- VW, 4, divisor and remainder width; VW <= DW.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset.
- in_valid  input  1  dividend/divisor present.
- in_ready  output  1  block can accept an operation.
- dividend  input  DW  numerator.
- divisor  input  VW  denominator.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- quotient  output  DW  floor(dividend/divisor).
- remainder  output  VW  dividend mod divisor.
- div_by_zero  output  1  result belongs to divisor==0 operation.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset (rst high at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0.
  - quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
  - Reset has priority over every other event.
- Reset mid-RUN or in DONE: the operation is discarded with no output. in_ready is 1 in the cycle after reset.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid & in_ready: latch dividend into a shift register and divisor into a register, clear the partial remainder and counter.
  - divisor!=0: go to RUN.
  - divisor==0: go to DONE with quotient=all ones, remainder=0, div_by_zero=1.
- RUN, one restoring step per edge:
  - s = {r, dividend shift-reg MSB}, VW+1 bits.
  - If s >= {0,divisor}: r = s - divisor and qbit=1; else r = s[VW-1:0] and qbit=0.
  - The quotient shift register shifts left, inserting qbit. The dividend shift register shifts left.
  - The counter increments. After the DW-th step, go to DONE with div_by_zero=0.
- Latency, with the accept cycle as cycle 0:
  - out_valid is first high in cycle DW+1 (9 by default).
  - For the divide-by-zero case, out_valid is first high in cycle 1.
- DONE:
  - out_valid=1, in_ready=0.
  - quotient, remainder and div_by_zero are held stable until out_valid & out_ready at an edge, then go to IDLE.
  - No same-cycle bypass: the next accept can happen no earlier than the cycle after the handshake.
- in_valid while in_ready=0 is ignored. The source must hold it; the block does not queue it.
- out_ready is ignored outside DONE.
- in_ready is 0 throughout RUN and DONE.
- Widths:
  - Partial remainder is VW bits and always < divisor.
  - The compare/subtract is VW+1 bits.
  - No overflow is possible, since quotient <= dividend.
- Outputs between operations keep their last values. Only out_valid qualifies them.

Decomposition:
- Package divider_pkg:
  - localparams DW_DEF=8, VW_DEF=4.
  - enum state_t {IDLE, RUN, DONE}.
  - Counter width function clog2(DW+1).
- Sub-module div_step: combinational single restoring step.
  - Inputs: r[VW-1:0], bit_in, divisor[VW-1:0].
  - Outputs: r_next[VW-1:0], qbit.
  - Reusable for a future unrolled/pipelined variant.
- Top module: FSM, counter, shift registers.

Test Plan:
- dividend=13, divisor=4, out_ready=1 -> out_valid in cycle 9 for exactly 1 cycle, quotient=3, remainder=1, div_by_zero=0, in_ready high in cycle 10.
- dividend=225, divisor=15 -> quotient=15, remainder=0. dividend=255, divisor=1 -> quotient=255, remainder=0. dividend=7, divisor=9 -> quotient=0, remainder=7.
- dividend=200, divisor=0 -> out_valid in cycle 1, quotient=8'hFF, remainder=0, div_by_zero=1. Next operation 10/3 -> quotient=3, remainder=1, div_by_zero=0.
- 100/7 with out_ready low for cycles 9-14 plus in_valid=1 with 50/5 throughout:
  - quotient=14 and remainder=2 are held stable, in_ready=0.
  - Handshake at cycle 15.
  - 50/5 is accepted no earlier than cycle 16, and yields quotient=10, remainder=0.
- rst pulsed in cycle 4 of a 99/8 operation -> next cycle: out_valid=0, quotient=0, remainder=0, in_ready=1. A following 99/8 yields quotient=12, remainder=3.
- Exhaustive sweep of all 256x16 pairs with random out_ready stalls -> nonzero divisors satisfy quotient*divisor+remainder==dividend and remainder<divisor; divisor==0 gives the div_by_zero response above.

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the sequential restoring divider.
//   DW_DEF / VW_DEF : default dividend / divisor widths
//   state_t         : controller states
//   cnt_w()         : width of the iteration counter for a given DW
package divider_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to represent 0..DW.
    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/divider_8by4_seq_div_step.sv
// div_step: one combinational restoring-division step.
//   r       : current partial remainder (always < divisor)
//   bit_in  : next dividend bit shifted into the remainder
//   divisor : denominator
//   r_next  : partial remainder after the step
//   qbit    : quotient bit produced by this step
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] r,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] r_next,
    output logic          qbit
);

    logic [VW:0] s;
    logic [VW:0] diff;

    always_comb begin
        s    = {r, bit_in};
        diff = s - {1'b0, divisor};
        // Since r < divisor, s < 2*divisor, so one subtraction always
        // brings the result back under divisor and it fits in VW bits.
        if (s >= {1'b0, divisor}) begin
            r_next = diff[VW-1:0];
            qbit   = 1'b1;
        end else begin
            r_next = s[VW-1:0];
            qbit   = 1'b0;
        end
    end

endmodule

// File: rtl/divider_8by4_seq.sv
// divider_8by4_seq: sequential unsigned restoring divider, one quotient bit
// per clock, valid/ready on both sides.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : operand handshake (dividend, divisor)
//   out_valid/out_ready: result handshake (quotient, remainder, div_by_zero)
// Result appears DW+1 cycles after the accept cycle (1 cycle for divisor 0)
// and is held until taken. Outputs keep their last values between results.
module divider_8by4_seq
    import divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = cnt_w(DW);

    state_t        state_q,     state_d;
    logic [DW-1:0] dvd_q,       dvd_d;        // dividend shift register
    logic [VW-1:0] dvs_q,       dvs_d;
    logic [VW-1:0] rem_q,       rem_d;        // partial remainder
    logic [DW-1:0] quo_q,       quo_d;        // quotient shift register
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] quotient_q,  quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          dbz_q,       dbz_d;

    logic [VW-1:0] r_next;
    logic          qbit;

    div_step #(.VW(VW)) u_step (
        .r       (rem_q),
        .bit_in  (dvd_q[DW-1]),
        .divisor (dvs_q),
        .r_next  (r_next),
        .qbit    (qbit)
    );

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dvd_d      = dividend;
                    dvs_d      = divisor;
                    rem_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        // Skip iteration: report all-ones quotient right away.
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = r_next;
                quo_d = {quo_q[DW-2:0], qbit};
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d     = DONE;
                    quotient_d  = {quo_q[DW-2:0], qbit};
                    remainder_d = r_next;
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_8by4_seq.sv
// Self-checking bench for divider_8by4_seq: directed vector table, hand-written
// stall and reset sequences, and an exhaustive operand sweep with random
// output stalls checked against plain integer division.
module tb_divider_8by4_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    divider_8by4_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dvd;
        int dvs;
        int q;
        int r;
        int dbz;
        int lat;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Presents an operation and returns in cycle 1 (the cycle after accept).
    task automatic start_op(input int a, input int b);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        chk("accept_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        dividend = a[7:0];
        divisor  = b[3:0];
        tick();
        in_valid = 1'b0;
    endtask

    // Counts cycles (from cycle 1) until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int eq, er, edbz;
        bit hs;
        int g;

        vecs[0] = '{13,  4,   3, 1, 0, 9};
        vecs[1] = '{225, 15,  15, 0, 0, 9};
        vecs[2] = '{255, 1,  255, 0, 0, 9};
        vecs[3] = '{7,   9,   0, 7, 0, 9};
        vecs[4] = '{200, 0,  255, 0, 1, 1};
        vecs[5] = '{10,  3,   3, 1, 0, 9};

        rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;

        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quotient",  int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz",       int'(div_by_zero), 0);

        // Directed table with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b1;
            start_op(vecs[i].dvd, vecs[i].dvs);
            wait_valid(lat);
            chk("vec_latency",   lat, vecs[i].lat);
            chk("vec_quotient",  int'(quotient), vecs[i].q);
            chk("vec_remainder", int'(remainder), vecs[i].r);
            chk("vec_dbz",       int'(div_by_zero), vecs[i].dbz);
            chk("vec_busy",      int'(in_ready), 0);
            tick();
            chk("vec_valid_drop", int'(out_valid), 0);
            chk("vec_ready_back", int'(in_ready), 1);
        end

        // 100/7 held under backpressure while 50/5 waits at the input.
        out_ready = 1'b1;
        start_op(100, 7);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 8'd50;
        divisor   = 4'd5;
        wait_valid(lat);
        chk("hold_latency", lat, 9);
        for (int c = 9; c <= 15; c++) begin
            chk("hold_valid",     int'(out_valid), 1);
            chk("hold_quotient",  int'(quotient), 14);
            chk("hold_remainder", int'(remainder), 2);
            chk("hold_in_ready",  int'(in_ready), 0);
            if (c == 15) out_ready = 1'b1;
            tick();
        end
        // Cycle 16: back in IDLE, pending 50/5 accepted at this edge.
        chk("hs_valid_drop", int'(out_valid), 0);
        chk("hs_in_ready",   int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("second_busy", int'(in_ready), 0);
        wait_valid(lat);
        chk("second_latency",   lat, 9);
        chk("second_quotient",  int'(quotient), 10);
        chk("second_remainder", int'(remainder), 0);
        tick();

        // Reset in cycle 4 of 99/8 discards the operation.
        out_ready = 1'b1;
        start_op(99, 8);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid",     int'(out_valid), 0);
        chk("midrst_quotient",  int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_in_ready",  int'(in_ready), 1);
        start_op(99, 8);
        wait_valid(lat);
        chk("after_rst_latency",   lat, 9);
        chk("after_rst_quotient",  int'(quotient), 12);
        chk("after_rst_remainder", int'(remainder), 3);
        tick();

        // Exhaustive sweep with random output stalls.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    eq = 255; er = 0; edbz = 1;
                end else begin
                    eq = a / b; er = a % b; edbz = 0;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                start_op(a, b);
                wait_valid(lat);
                chk("sweep_latency", lat, (b == 0) ? 1 : 9);
                hs = 1'b0;
                g = 0;
                while (!hs && g < 50) begin
                    chk("sweep_valid",     int'(out_valid), 1);
                    chk("sweep_quotient",  int'(quotient), eq);
                    chk("sweep_remainder", int'(remainder), er);
                    chk("sweep_dbz",       int'(div_by_zero), edbz);
                    if (b != 0) begin
                        chk("sweep_roundtrip", int'(quotient) * b + int'(remainder), a);
                        chk("sweep_rem_lt_dvs", int'(int'(remainder) < b), 1);
                    end
                    out_ready = ($urandom_range(0, 3) != 0);
                    hs = out_ready;
                    tick();
                    g++;
                end
                chk("sweep_handshake", int'(hs), 1);
                chk("sweep_valid_drop", int'(out_valid), 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
